// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit memory router.
//   - SZ_B/SZ_H/SZ_W/SZ_D : request size encodings (byte/half/word/double)
//   - lsu_state_e         : router FSM states
//   - DEF_CACHE_BASE/LIMIT: default cacheable window (inclusive, on addr[31:0])
//   - misaligned()        : natural-alignment check for a given access size
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [31:0] DEF_CACHE_BASE  = 32'h8000_0000;
    localparam logic [31:0] DEF_CACHE_LIMIT = 32'h87ff_ffff;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CWAIT = 2'd1,
        DWAIT = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // An access is misaligned when its address is not a multiple of 2^size bytes.
    function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_router_if.sv
// lsu_mem_router_if: bundles the execute-side request/response handshake and
// the two downstream memory ports (c_* = dcache, d_* = uncached device).
//   modport slave  : the router itself
//   modport master : the execute stage plus memory side around the router
interface lsu_mem_router_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wen;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [1:0]              req_size;
    logic                    req_unsigned;
    logic [DATA_WIDTH-1:0]   req_wdata;

    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    logic                    c_valid;
    logic                    c_wen;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [DATA_WIDTH-1:0]   c_wdata;
    logic [DATA_WIDTH/8-1:0] c_wmask;
    logic [DATA_WIDTH-1:0]   c_rdata;
    logic                    c_done;

    logic                    d_valid;
    logic                    d_wen;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_wmask;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_done;

    modport slave (
        input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output c_valid, c_wen, c_addr, c_wdata, c_wmask,
        input  c_rdata, c_done,
        output d_valid, d_wen, d_addr, d_wdata, d_wmask,
        input  d_rdata, d_done
    );

    modport master (
        output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  c_valid, c_wen, c_addr, c_wdata, c_wmask,
        output c_rdata, c_done,
        input  d_valid, d_wen, d_addr, d_wdata, d_wmask,
        output d_rdata, d_done
    );

endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane logic.
//   size, off, is_unsigned : captured request attributes (off = byte offset in the bus word)
//   load_raw  -> load_data : raw lane data shifted down, truncated to size, sign/zero extended
//   store_in  -> store_data: right-aligned store data shifted up into its lanes
//   is_store  -> store_mask: byte enables for a store, all zero for a load
module lsu_lane_align import lsu_pkg::*; #(
    parameter int DATA_WIDTH = 64,
    localparam int OFF_W = $clog2(DATA_WIDTH/8),
    localparam int IDX_W = $clog2(DATA_WIDTH),
    localparam int MW    = DATA_WIDTH/8
) (
    input  logic [1:0]            size,
    input  logic [OFF_W-1:0]      off,
    input  logic                  is_unsigned,
    input  logic                  is_store,
    input  logic [DATA_WIDTH-1:0] load_raw,
    output logic [DATA_WIDTH-1:0] load_data,
    input  logic [DATA_WIDTH-1:0] store_in,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic [MW-1:0]         store_mask
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep;
    logic [IDX_W-1:0]      sign_idx;
    logic                  sign_bit;
    logic [MW-1:0]         mask_base;

    // Load path: keep the low 8<<size bits and fill the rest with the sign
    // bit (or zeros). A full-width access keeps everything, so the unsigned
    // flag has no effect there.
    always_comb begin
        shifted = load_raw >> {off, 3'b000};
        case (size)
            SZ_B: begin
                keep     = DATA_WIDTH'(8'hFF);
                sign_idx = IDX_W'(7);
            end
            SZ_H: begin
                keep     = DATA_WIDTH'(16'hFFFF);
                sign_idx = IDX_W'(15);
            end
            SZ_W: begin
                keep     = DATA_WIDTH'(32'hFFFF_FFFF);
                sign_idx = IDX_W'(31);
            end
            default: begin
                keep     = '1;
                sign_idx = IDX_W'(DATA_WIDTH-1);
            end
        endcase
        sign_bit  = ~is_unsigned & shifted[sign_idx];
        load_data = (shifted & keep) | ({DATA_WIDTH{sign_bit}} & ~keep);
    end

    // Store path: data and byte enables move up by the byte offset.
    always_comb begin
        case (size)
            SZ_B:    mask_base = MW'(1);
            SZ_H:    mask_base = MW'(2'b11);
            SZ_W:    mask_base = MW'(4'hF);
            default: mask_base = '1;
        endcase
        store_data = store_in << {off, 3'b000};
        store_mask = is_store ? (mask_base << off) : '0;
    end

endmodule

// File: rtl/lsu_mem_router.sv
// lsu_mem_router: load/store unit front end. Accepts one access per
// valid/ready handshake, checks alignment/size, routes it to the dcache port
// (addr[31:0] inside CACHE_BASE..CACHE_LIMIT) or the device port, waits for
// done or a TMO_CYCLES timeout, then pulses resp_valid for one cycle.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : lsu_mem_router_if.slave (request, response, c_* and d_* ports)
module lsu_mem_router import lsu_pkg::*; #(
    parameter int          ADDR_WIDTH  = 64,
    parameter int          DATA_WIDTH  = 64,
    parameter logic [31:0] CACHE_BASE  = DEF_CACHE_BASE,
    parameter logic [31:0] CACHE_LIMIT = DEF_CACHE_LIMIT,
    parameter int          TMO_CYCLES  = 255,
    localparam int OFF_W = $clog2(DATA_WIDTH/8),
    localparam int MW    = DATA_WIDTH/8,
    localparam int CNT_W = $clog2(TMO_CYCLES+1)
) (
    input logic              clk,
    input logic              rst,
    lsu_mem_router_if.slave  bus
);

    lsu_state_e state, state_next;

    logic                  cap_wen;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [1:0]            cap_size;
    logic                  cap_unsigned;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_err_q;

    logic                  acc_err;
    logic                  cacheable;
    logic                  sel_done;
    logic                  tmo;
    logic                  c_sel;
    logic                  d_sel;
    logic [DATA_WIDTH-1:0] raw_rdata;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_data;
    logic [MW-1:0]         store_mask;

    // Decisions taken at accept time come straight from the request; the
    // wait-state decisions use the selected port only, so done on the other
    // port never completes an access.
    always_comb begin
        acc_err   = misaligned(bus.req_addr[2:0], bus.req_size)
                  | ((bus.req_size == SZ_D) && (DATA_WIDTH == 32));
        cacheable = (bus.req_addr[31:0] >= CACHE_BASE) && (bus.req_addr[31:0] <= CACHE_LIMIT);
        c_sel     = (state == CWAIT);
        d_sel     = (state == DWAIT);
        sel_done  = (c_sel & bus.c_done) | (d_sel & bus.d_done);
        // The count is the number of wait cycles already completed, so the
        // current cycle is the last one allowed when count+1 hits the limit.
        tmo       = (int'(cnt) + 1) >= TMO_CYCLES;
        raw_rdata = d_sel ? bus.d_rdata : bus.c_rdata;
    end

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size        (cap_size),
        .off         (cap_addr[OFF_W-1:0]),
        .is_unsigned (cap_unsigned),
        .is_store    (cap_wen),
        .load_raw    (raw_rdata),
        .load_data   (load_data),
        .store_in    (cap_wdata),
        .store_data  (store_data),
        .store_mask  (store_mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Done has priority over timeout when both land in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (acc_err)        state_next = RESP;
                    else if (cacheable) state_next = CWAIT;
                    else                state_next = DWAIT;
                end
            end
            CWAIT, DWAIT: begin
                if (sel_done || tmo) state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Downstream fields are zeroed on the idle port so only the selected one
    // ever shows a live access.
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = resp_rdata_q;
        bus.resp_err   = resp_err_q;

        bus.c_valid    = c_sel;
        bus.c_wen      = c_sel & cap_wen;
        bus.c_addr     = c_sel ? cap_addr   : '0;
        bus.c_wdata    = c_sel ? store_data : '0;
        bus.c_wmask    = c_sel ? store_mask : '0;

        bus.d_valid    = d_sel;
        bus.d_wen      = d_sel & cap_wen;
        bus.d_addr     = d_sel ? cap_addr   : '0;
        bus.d_wdata    = d_sel ? store_data : '0;
        bus.d_wmask    = d_sel ? store_mask : '0;
    end

    // Request capture, wait counter and the response registers, which hold
    // their value after the RESP pulse until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_wen      <= 1'b0;
            cap_addr     <= '0;
            cap_size     <= SZ_B;
            cap_unsigned <= 1'b0;
            cap_wdata    <= '0;
            cnt          <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.req_valid) begin
                        cap_wen      <= bus.req_wen;
                        cap_addr     <= bus.req_addr;
                        cap_size     <= bus.req_size;
                        cap_unsigned <= bus.req_unsigned;
                        cap_wdata    <= bus.req_wdata;
                        if (acc_err) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end
                    end
                end
                CWAIT, DWAIT: begin
                    cnt <= cnt + 1'b1;
                    if (sel_done) begin
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= cap_wen ? '0 : load_data;
                    end else if (tmo) begin
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_router.sv
// tb_lsu_mem_router: self-checking bench for lsu_mem_router (TMO_CYCLES=8).
// Drives directed and random accesses, plays the dcache/device side, and
// compares against a reference model built from the access rules.
module tb_lsu_mem_router;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int TMO = 8;

    logic clk;
    logic rst;

    int errors;
    int checks;

    lsu_mem_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    lsu_mem_router #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .CACHE_BASE  (32'h8000_0000),
        .CACHE_LIMIT (32'h87ff_ffff),
        .TMO_CYCLES  (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
        end
    endtask

    // Reference: take the addressed bytes, then extend to 64 bits.
    function automatic logic [63:0] modelLoad(input logic [63:0] raw, input int off, input int size, input bit uns);
        logic [63:0] v;
        int nbits;
        nbits = 8 << size;
        v = raw >> (8 * off);
        if (nbits < 64) begin
            if (!uns && v[nbits-1]) v = v | (~64'd0 << nbits);
            else                    v = v & ~(~64'd0 << nbits);
        end
        return v;
    endfunction

    function automatic logic [7:0] modelMask(input int off, input int size);
        logic [15:0] m;
        m = ((16'd1 << (1 << size)) - 16'd1) << off;
        return m[7:0];
    endfunction

    // One complete access. done_at: cycle (1 = first valid cycle) on which the
    // selected port reports done; 0 means never. noise drives random done on
    // the port that was not selected.
    task automatic applyStimulus(input logic wen, input logic [63:0] addr, input int size,
                                 input bit uns, input logic [63:0] wdata,
                                 input logic [63:0] mem_rdata, input int done_at, input bit noise);
        bit          exp_err, exp_cache;
        int          off, exp_resp_k, exp_cnt, k, resp_k, c_cnt, d_cnt;
        logic [63:0] exp_rdata, exp_wdata;
        logic [7:0]  exp_mask;
        bit          got;

        off       = int'(addr[2:0]);
        exp_err   = (addr % (64'd1 << size)) != 0;
        exp_cache = (addr[31:0] >= 32'h8000_0000) && (addr[31:0] <= 32'h87ff_ffff);
        exp_wdata = wdata << (8 * off);
        exp_mask  = wen ? modelMask(off, size) : 8'h00;
        if (exp_err) begin
            exp_resp_k = 1; exp_cnt = 0; exp_rdata = 64'd0;
        end else if (done_at >= 1 && done_at <= TMO) begin
            exp_resp_k = done_at + 1; exp_cnt = done_at;
            exp_rdata = wen ? 64'd0 : modelLoad(mem_rdata, off, size, uns);
        end else begin
            exp_resp_k = TMO + 1; exp_cnt = TMO; exp_err = 1'b1; exp_rdata = 64'd0;
        end

        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_wen      = wen;
        bus.req_addr     = addr;
        bus.req_size     = 2'(size);
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        checkOutput("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wen   = ~wen;
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        bus.req_size  = 2'($urandom_range(0, 3));

        k = 1; got = 0; resp_k = 0; c_cnt = 0; d_cnt = 0;
        while (!got && k <= 40) begin
            bus.c_done = 1'b0;
            bus.d_done = 1'b0;
            if (bus.resp_valid) begin
                got = 1; resp_k = k;
            end else begin
                checkOutput("ready_busy", 64'(bus.req_ready), 64'd0);
                if (bus.c_valid) c_cnt++;
                if (bus.d_valid) d_cnt++;
                if (bus.c_valid || bus.d_valid) begin
                    checkOutput("port_addr",  exp_cache ? bus.c_addr  : bus.d_addr,  addr);
                    checkOutput("port_wen",   64'(exp_cache ? bus.c_wen : bus.d_wen), 64'(wen));
                    checkOutput("port_wdata", exp_cache ? bus.c_wdata : bus.d_wdata, exp_wdata);
                    checkOutput("port_wmask", 64'(exp_cache ? bus.c_wmask : bus.d_wmask), 64'(exp_mask));
                end
                if (exp_cache) begin
                    bus.c_rdata = mem_rdata;
                    bus.c_done  = (k == done_at);
                    if (noise) begin bus.d_done = 1'b1; bus.d_rdata = {$urandom, $urandom}; end
                end else begin
                    bus.d_rdata = mem_rdata;
                    bus.d_done  = (k == done_at);
                    if (noise) begin bus.c_done = 1'b1; bus.c_rdata = {$urandom, $urandom}; end
                end
                @(negedge clk);
                k++;
            end
        end
        bus.c_done = 1'b0;
        bus.d_done = 1'b0;

        checkOutput("resp_seen",   64'(got), 64'd1);
        checkOutput("resp_cycle",  64'(resp_k), 64'(exp_resp_k));
        checkOutput("resp_err",    64'(bus.resp_err), 64'(exp_err));
        checkOutput("resp_rdata",  bus.resp_rdata, exp_rdata);
        checkOutput("c_valid_cnt", 64'(c_cnt), 64'(exp_cache ? exp_cnt : 0));
        checkOutput("d_valid_cnt", 64'(d_cnt), 64'(exp_cache ? 0 : exp_cnt));
        @(negedge clk);
        checkOutput("resp_pulse",  64'(bus.resp_valid), 64'd0);
        checkOutput("ready_after", 64'(bus.req_ready), 64'd1);
        checkOutput("rdata_held",  bus.resp_rdata, exp_rdata);
        checkOutput("err_held",    64'(bus.resp_err), 64'(exp_err));
    endtask

    logic [63:0] r_addr;
    int          r_size;

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_size = '0;
        bus.req_unsigned = 1'b0; bus.req_wdata = '0;
        bus.c_rdata = '0; bus.c_done = 1'b0; bus.d_rdata = '0; bus.d_done = 1'b0;

        #12;
        checkOutput("rst_ready",      64'(bus.req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("rst_resp_err",   64'(bus.resp_err), 64'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 64'd0);
        checkOutput("rst_c_valid",    64'(bus.c_valid), 64'd0);
        checkOutput("rst_d_valid",    64'(bus.d_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 64'h8000_0004, 2, 1'b0, 64'd0, 64'h8000_0000_1234_5678, 1, 1'b0);
        applyStimulus(1'b1, 64'h8000_0006, 1, 1'b0, 64'h0000_0000_0000_ABCD, 64'h1111_2222_3333_4444, 1, 1'b0);
        applyStimulus(1'b0, 64'hA000_0049, 0, 1'b1, 64'd0, 64'h0000_0000_0000_F100, 3, 1'b0);
        applyStimulus(1'b0, 64'h8000_0002, 2, 1'b0, 64'd0, 64'hDEAD_BEEF_DEAD_BEEF, 1, 1'b0);
        applyStimulus(1'b0, 64'hA000_0000, 3, 1'b0, 64'd0, 64'd0, 0, 1'b0);
        applyStimulus(1'b0, 64'hA000_0010, 3, 1'b0, 64'd0, 64'hCAFE_F00D_0BAD_F00D, TMO, 1'b0);
        applyStimulus(1'b0, 64'h87FF_FFFF, 0, 1'b0, 64'd0, 64'h8000_0000_0000_0000, 2, 1'b1);
        applyStimulus(1'b0, 64'h8800_0000, 0, 1'b0, 64'd0, 64'h0000_0000_0000_0080, 2, 1'b1);
        applyStimulus(1'b0, 64'h7FFF_FFFE, 1, 1'b0, 64'd0, 64'h8001_0000_0000_0000, 1, 1'b1);
        applyStimulus(1'b0, 64'h1_8000_0000, 3, 1'b1, 64'd0, 64'hFEDC_BA98_7654_3210, 1, 1'b0);
        applyStimulus(1'b1, 64'h8000_0104, 3, 1'b0, 64'h0102_0304_0506_0708, 64'd0, 2, 1'b0);

        $display("[TB] reset during device wait");
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 64'hA000_0100;
        bus.req_size = 2'd3; bus.req_unsigned = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_d_valid", 64'(bus.d_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_d_valid", 64'(bus.d_valid), 64'd0);
        checkOutput("mid_rst_ready",   64'(bus.req_ready), 64'd1);
        checkOutput("mid_rst_c_valid", 64'(bus.c_valid), 64'd0);
        checkOutput("mid_rst_resp",    64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 64'h8000_0008, 3, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF, 2, 1'b0);

        $display("[TB] random accesses");
        for (int n = 0; n < 40; n++) begin
            r_size = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0, 1:    r_addr = {32'($urandom_range(0, 3)), 32'h8000_0000 | ($urandom & 32'h07FF_FFFF)};
                2:       r_addr = {32'd0, 32'hA000_0000 | ($urandom & 32'h0000_FFFF)};
                default: r_addr = {32'd0, 32'h1000_0000 | ($urandom & 32'h00FF_FFFF)};
            endcase
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((64'd1 << r_size) - 64'd1);
            applyStimulus(1'($urandom_range(0, 1)), r_addr, r_size, 1'($urandom_range(0, 1)),
                          {$urandom, $urandom}, {$urandom, $urandom},
                          $urandom_range(0, 10), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got running required done");
        $fatal(1, "[TB] global timeout");
    end

endmodule

// File: doc/lsu_mem_router.md
Name: lsu_mem_router

Overview:
- Parametrised load/store access unit between the execute stage and the memory side.
- Accepts one load or store per valid/ready handshake and aligns load data by byte offset, with sign or zero extension.
- Generates the store byte mask and store data.
- Routes each access to the dcache port or the uncached device port by address range; timeouts and misalignment are reported as errors.

Parameters:
ADDR_WIDTH, 64, request/downstream address width
DATA_WIDTH, 64, data width; legal values 32 or 64
CACHE_BASE, 32'h80000000, lowest cacheable address (compared against addr[31:0])
CACHE_LIMIT, 32'h87ffffff, highest cacheable address, inclusive
TMO_CYCLES, 255, downstream wait limit in cycles; must be at least 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_wen  in  1  1=store, 0=load
req_addr  in  ADDR_WIDTH  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=double
req_unsigned  in  1  zero-extend load
req_wdata  in  DATA_WIDTH  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, unsupported size, or timeout
c_valid, d_valid  out  1  cache/device access request
c_wen, d_wen  out  1  store
c_addr, d_addr  out  ADDR_WIDTH  byte address
c_wdata, d_wdata  out  DATA_WIDTH  lane-shifted store data
c_wmask, d_wmask  out  DATA_WIDTH/8  byte enables
c_rdata, d_rdata  in  DATA_WIDTH  raw lane data, valid with done
c_done, d_done  in  1  single-cycle completion

Behaviour:
Reset:
- state=IDLE
- req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0
- c_valid=d_valid=0, timeout counter=0, captured request cleared.

States:
- IDLE
- CWAIT
- DWAIT
- RESP

Request acceptance:
- req_ready=1 only in IDLE.
- On accept, capture wen, addr, size, unsigned and wdata.

Error check at accept:
- Error if addr is not a multiple of 2^size bytes.
- Error if size=3 when DATA_WIDTH=32.
- Error path: RESP next cycle with resp_err=1; no downstream access is made.

Routing at accept:
- Cacheable if CACHE_BASE <= addr[31:0] <= CACHE_LIMIT, using the request address only.
- Cacheable goes to CWAIT, otherwise DWAIT.

CWAIT/DWAIT:
- The selected x_valid is held at 1 with stable address, wdata, wmask and wen.
- The other port stays 0.
- The counter increments each cycle.
- On x_done, capture x_rdata and go to RESP with err=0.
- If the counter reaches TMO_CYCLES without done: drop x_valid, go to RESP with err=1.
- Done and timeout in the same cycle: done wins.
- Done on the unselected port is ignored.

RESP:
- resp_valid=1 for exactly one cycle.
- resp_rdata and resp_err are held until the next RESP.
- Then go to IDLE and clear the counter.

Latency:
- Accept at cycle T; x_valid high from T+1.
- Done at T+1 gives resp_valid at T+2 and req_ready at T+3.
- Error path: resp_valid at T+1.

Lane arithmetic (OFF = addr[log2(DATA_WIDTH/8)-1:0]):
- Load: shifted = rdata >> (8*OFF).
- Take the low 8<<size bits; sign-extend unless req_unsigned is set.
- Full-width load ignores unsigned.
- Store: x_wdata = req_wdata << (8*OFF).
- Store: x_wmask = ((1<<(1<<size))-1) << OFF.
- Loads drive wmask=0.

Reset mid-operation:
- Everything returns to reset values immediately.
- The outstanding downstream access is abandoned; downstream blocks share rst.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - the state enum
  - default CACHE_BASE/CACHE_LIMIT constants
- One sub-module, lsu_lane_align: combinational load extract/extend and store data/mask generation, parametrised on DATA_WIDTH.

Test Plan:
- Cached lw: addr 0x80000004, c_rdata 0x80000000_12345678, done 1 cycle after c_valid -> c_valid T+1 only, resp_valid T+2, resp_rdata 0xFFFFFFFF_80000000, err 0.
- Cached sh: addr 0x80000006, wdata 0xABCD -> c_wmask 0xC0, c_wdata 0xABCD0000_00000000; resp_rdata 0.
- Device lbu: addr 0xA0000049, d_rdata 0x0000_0000_0000_F100, done after 3 cycles -> d_valid held 3 cycles, c_valid stays 0; resp_rdata 0xF1.
- Misaligned lw: addr 0x80000002 -> no c_valid/d_valid, resp_valid T+1, resp_err 1.
- Timeout: TMO_CYCLES=8, device never done -> d_valid high 8 cycles, then resp_err 1, req_ready back high the cycle after resp_valid.
- Reset: rst low while in DWAIT -> d_valid 0 and req_ready 1 immediately; a following cached ld completes normally.
